// File: rtl/mips_top_module.sv
// Single-cycle 32-bit MIPS core: fetch, decode, execute, memory and writeback all complete in one clk cycle.
// Latency: one instruction per clk; register/memory results are visible the cycle after their posedge.
// Backpressure: none; asserting instr_WE stalls the core while the instruction memory is being loaded.
//
// Ports:
//   clk        - single clock, all state updates on posedge
//   rstn       - synchronous reset, active-high (1 = reset): PC, register file, load pointer cleared
//   instr_WE   - instruction-memory load enable (stalls execution while high)
//   instr_WD   - instruction word written at the load pointer
//   test_value - combinational read of register TEST_REG ($s0)
//
// Optional feature macro: MIPS_EXT_ISA_EN adds bne, andi, ori and nor.
// Without it those encodings execute as NOPs (PC+4 only).

module mips_instr_mem #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] wd,
    input  logic [7:0]  rd_addr,
    output logic [31:0] rd_dat
);
    // Contents are never cleared by reset; only the load pointer is.
    logic [31:0] I_MEM [0:DEPTH-1];
    logic [7:0]  ptr_q;
    logic [7:0]  ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (we) begin
            ptr_d = ptr_q + 8'd1;   // 8-bit pointer wraps 255 -> 0
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Reset wins over a simultaneous load request.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            I_MEM[ptr_q] <= wd;
        end
    end

    assign rd_dat = I_MEM[rd_addr];
endmodule

module mips_top_module #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int TEST_REG   = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_WE,
    input  logic [31:0] instr_WD,
    output logic [31:0] test_value
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ---------------- state ----------------
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] rf_q [0:31];
    logic [31:0] dmem [0:DMEM_DEPTH-1];

    // ---------------- fetch ----------------
    logic [31:0] instr;

    mips_instr_mem #(
        .DEPTH (IMEM_DEPTH)
    ) INSTRUCTION_MEMORY (
        .clk     (clk),
        .rst     (rstn),
        .we      (instr_WE),
        .wd      (instr_WD),
        .rd_addr (pc_q[9:2]),
        .rd_dat  (instr)
    );

    // ---------------- decode ----------------
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] addr26;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] mem_addr;
    logic        exec;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign addr26   = instr[25:0];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // $0 is forced to zero on read, so its storage content never matters.
    assign rs_val   = (rs == 5'd0) ? 32'h0 : rf_q[rs];
    assign rt_val   = (rt == 5'd0) ? 32'h0 : rf_q[rt];

    assign pc_plus4  = pc_q + 32'd4;
    assign br_target = pc_plus4 + {imm_sext[29:0], 2'b00};
    assign mem_addr  = rs_val + imm_sext;

    // The core only advances on cycles that are neither reset nor load.
    assign exec = !rstn && !instr_WE;

    // ---------------- execute / writeback control ----------------
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        dmem_we;

    always_comb begin
        pc_d    = pc_q;
        rf_we   = 1'b0;
        rf_wa   = rt;
        rf_wd   = 32'h0;
        dmem_we = 1'b0;

        if (exec) begin
            pc_d = pc_plus4;
            unique case (op)
                OP_RTYPE: begin
                    rf_wa = rd;
                    unique case (funct)
                        FN_ADD: begin rf_we = 1'b1; rf_wd = rs_val + rt_val; end
                        FN_SUB: begin rf_we = 1'b1; rf_wd = rs_val - rt_val; end
                        FN_AND: begin rf_we = 1'b1; rf_wd = rs_val & rt_val; end
                        FN_OR:  begin rf_we = 1'b1; rf_wd = rs_val | rt_val; end
                        FN_SLT: begin
                            rf_we = 1'b1;
                            rf_wd = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
                        end
`ifdef MIPS_EXT_ISA_EN
                        FN_NOR: begin rf_we = 1'b1; rf_wd = ~(rs_val | rt_val); end
`endif
                        default: ;
                    endcase
                end
                OP_ADDI: begin
                    rf_we = 1'b1;
                    rf_wd = rs_val + imm_sext;
                end
                OP_LW: begin
                    rf_we = 1'b1;
                    rf_wd = dmem[mem_addr[9:2]];
                end
                OP_SW: begin
                    dmem_we = 1'b1;
                end
                OP_BEQ: begin
                    if (rs_val == rt_val) begin
                        pc_d = br_target;
                    end
                end
                OP_J: begin
                    pc_d = {pc_plus4[31:28], addr26, 2'b00};
                end
`ifdef MIPS_EXT_ISA_EN
                OP_BNE: begin
                    if (rs_val != rt_val) begin
                        pc_d = br_target;
                    end
                end
                OP_ANDI: begin
                    rf_we = 1'b1;
                    rf_wd = rs_val & imm_zext;
                end
                OP_ORI: begin
                    rf_we = 1'b1;
                    rf_wd = rs_val | imm_zext;
                end
`endif
                default: ;
            endcase
        end

        // Writes to $0 are dropped here rather than in the array.
        if (rf_wa == 5'd0) begin
            rf_we = 1'b0;
        end
    end

`ifndef MIPS_EXT_ISA_EN
    // Extension encodings decode as NOPs in this build; keep the names referenced.
    logic ext_unused;
    assign ext_unused = ^{OP_BNE, OP_ANDI, OP_ORI, FN_NOR, imm_zext};
`endif

    // ---------------- sequential state ----------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // Data memory is not cleared by reset; upper/low address bits alias.
    always_ff @(posedge clk) begin
        if (dmem_we) begin
            dmem[mem_addr[9:2]] <= rt_val;
        end
    end

    assign test_value = rf_q[TEST_REG];
endmodule

// File: tb/tb_mips_top_module.sv
module tb_mips_top_module;
    logic        clk;
    logic        rstn;
    logic        instr_WE;
    logic [31:0] instr_WD;
    logic [31:0] test_value;

    int n_cmp;
    int n_err;

    logic [31:0] prog [0:15];
    logic [31:0] exp_seq [0:15];

    mips_top_module dut (
        .clk        (clk),
        .rstn       (rstn),
        .instr_WE   (instr_WE),
        .instr_WD   (instr_WD),
        .test_value (test_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reset, then load all 16 words of prog[] through the load port.
    task automatic load_prog();
        rstn = 1'b1;
        instr_WE = 1'b0;
        tick();
        rstn = 1'b0;
        instr_WE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            instr_WD = prog[i];
            tick();
        end
        instr_WE = 1'b0;
        instr_WD = 32'h0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            prog[i] = 32'h0;
            exp_seq[i] = 32'h0;
        end
    endtask

    task automatic run_seq(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_step%0d", tag, i + 1), test_value, exp_seq[i]);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn = 1'b1;
        instr_WE = 1'b0;
        instr_WD = 32'h0;

        // Reset state
        tick();
        tick();
        chk("reset_tv", test_value, 32'h0);

        // All-NOP program keeps $s0 at 0
        clear_prog();
        load_prog();
        chk("nop_after_load", test_value, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        chk("nop_run10", test_value, 32'h0);

        // ALU program
        clear_prog();
        prog[0]  = 32'h20100005; exp_seq[0]  = 32'h00000005; // addi $s0,$0,5
        prog[1]  = 32'h20080007; exp_seq[1]  = 32'h00000005; // addi $t0,$0,7
        prog[2]  = 32'h02088020; exp_seq[2]  = 32'h0000000C; // add  $s0,$s0,$t0
        prog[3]  = 32'h00088022; exp_seq[3]  = 32'hFFFFFFF9; // sub  $s0,$0,$t0
        prog[4]  = 32'h0208802A; exp_seq[4]  = 32'h00000001; // slt  $s0,$s0,$t0 (-7<7)
        prog[5]  = 32'h2009000C; exp_seq[5]  = 32'h00000001; // addi $t1,$0,12
        prog[6]  = 32'h2010000A; exp_seq[6]  = 32'h0000000A; // addi $s0,$0,10
        prog[7]  = 32'h02098024; exp_seq[7]  = 32'h00000008; // and  $s0,$s0,$t1
        prog[8]  = 32'h02098025; exp_seq[8]  = 32'h0000000C; // or   $s0,$s0,$t1
        prog[9]  = 32'h2010FFFF; exp_seq[9]  = 32'hFFFFFFFF; // addi $s0,$0,-1
        prog[10] = 32'h02108020; exp_seq[10] = 32'hFFFFFFFE; // add  $s0,$s0,$s0 (carry dropped)
        prog[11] = 32'h0010802A; exp_seq[11] = 32'h00000000; // slt  $s0,$0,$s0 (0 < -2 false)
        load_prog();
        run_seq("alu", 12);

        // Memory program
        clear_prog();
        prog[0] = 32'h20081234; exp_seq[0] = 32'h00000000; // addi $t0,$0,0x1234
        prog[1] = 32'hAC080008; exp_seq[1] = 32'h00000000; // sw   $t0,8($0)
        prog[2] = 32'h8C100008; exp_seq[2] = 32'h00001234; // lw   $s0,8($0)
        prog[3] = 32'h20085678; exp_seq[3] = 32'h00001234; // addi $t0,$0,0x5678
        prog[4] = 32'hAC080408; exp_seq[4] = 32'h00001234; // sw   $t0,0x408($0) (aliases 8)
        prog[5] = 32'h8C100008; exp_seq[5] = 32'h00005678; // lw   $s0,8($0)
        prog[6] = 32'h00008020; exp_seq[6] = 32'h00000000; // add  $s0,$0,$0
        prog[7] = 32'h8C10000B; exp_seq[7] = 32'h00005678; // lw   $s0,0xB($0) (low bits ignored)
        load_prog();
        run_seq("mem", 8);

        // Control: beq skips the $s0 write, j loops back to 0
        clear_prog();
        prog[0] = 32'h10000001; // beq $0,$0,+1
        prog[1] = 32'h20100001; // addi $s0,$0,1 (skipped)
        prog[2] = 32'h08000000; // j 0
        load_prog();
        begin
            int bad_cycles;
            bad_cycles = 0;
            for (int i = 0; i < 50; i++) begin
                tick();
                if (test_value !== 32'h0) bad_cycles++;
            end
            chk("ctrl_skip_bad_cycles", bad_cycles, 32'h0);
        end
        chk("ctrl_skip_final", test_value, 32'h0);

        // Not-taken beq and backward beq accumulating into $s0
        clear_prog();
        prog[0] = 32'h20080001; exp_seq[0] = 32'h0; // addi $t0,$0,1
        prog[1] = 32'h10080001; exp_seq[1] = 32'h0; // beq  $0,$t0,+1 (not taken)
        prog[2] = 32'h22100003; exp_seq[2] = 32'h3; // addi $s0,$s0,3
        prog[3] = 32'h1000FFFC; exp_seq[3] = 32'h3; // beq  $0,$0,-4 -> PC 0
        exp_seq[4] = 32'h3;
        exp_seq[5] = 32'h3;
        exp_seq[6] = 32'h6;
        load_prog();
        run_seq("branch", 7);

        // $0 write discarded; extension ori
        clear_prog();
        prog[0] = 32'h20000005; exp_seq[0] = 32'h0; // addi $0,$0,5
        prog[1] = 32'h00008020; exp_seq[1] = 32'h0; // add  $s0,$0,$0
        prog[2] = 32'h3410FFFF;                     // ori  $s0,$0,0xFFFF
`ifdef MIPS_EXT_ISA_EN
        exp_seq[2] = 32'h0000FFFF;
`else
        exp_seq[2] = 32'h00000000;
`endif
        load_prog();
        run_seq("zero_reg", 3);

        // Load port: 3 load cycles, PC must not advance, then $s0=9 one cycle later
        rstn = 1'b1;
        tick();
        chk("ldport_reset_tv", test_value, 32'h0);
        rstn = 1'b0;
        instr_WE = 1'b1;
        instr_WD = 32'h20100009; tick();
        chk("ldport_load1_tv", test_value, 32'h0);
        instr_WD = 32'h00000000; tick();
        instr_WD = 32'h00000000; tick();
        chk("ldport_load3_tv", test_value, 32'h0);
        instr_WE = 1'b0;
        tick();
        chk("ldport_exec1_tv", test_value, 32'h00000009);

        // Reset and load together: reset wins, the word is not stored
        rstn = 1'b1;
        instr_WE = 1'b1;
        instr_WD = 32'h20100063; // addi $s0,$0,99 must not land in word 0
        tick();
        chk("rst_win_tv", test_value, 32'h0);
        rstn = 1'b0;
        instr_WD = 32'h20100007; // addi $s0,$0,7 goes to word 0
        tick();
        instr_WE = 1'b0;
        instr_WD = 32'h0;
        tick();
        chk("rst_win_exec", test_value, 32'h00000007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
